// File: rtl/pc_rx_packet_sequencer_if.sv
// Signal bundle between the packet sequencer, the UART receive FIFO and the DataManager.
// The master view belongs to the sequencer. The slave view is the FIFO/consumer side.
interface pc_rx_packet_sequencer_if;
    logic [31:0] i_fifo_output_word;
    logic        i_fifo_is_empty_sig;
    logic        o_read_next_byte_cmd;
    logic [31:0] o_payload_word;
    logic        o_payload_valid;
    logic        i_payload_ready;
    logic        o_payload_last;
    logic        o_packet_start;
    logic [15:0] o_packet_length;
    logic        o_error;
    logic [1:0]  o_error_code;
    logic [15:0] o_packet_count;
    logic [2:0]  o_state;

    modport master (
        input  i_fifo_output_word, i_fifo_is_empty_sig, i_payload_ready,
        output o_read_next_byte_cmd, o_payload_word, o_payload_valid, o_payload_last,
               o_packet_start, o_packet_length, o_error, o_error_code, o_packet_count, o_state
    );

    modport slave (
        output i_fifo_output_word, i_fifo_is_empty_sig, i_payload_ready,
        input  o_read_next_byte_cmd, o_payload_word, o_payload_valid, o_payload_last,
               o_packet_start, o_packet_length, o_error, o_error_code, o_packet_count, o_state
    );
endinterface

// File: rtl/pc_rx_packet_sequencer.sv
// Pops 32-bit words from the UART receive FIFO and frames them as resync/magic/length/payload.
// Only payload words are forwarded downstream. Stalled packets are aborted by a starvation timeout.
module pc_rx_packet_sequencer #(
    parameter logic [31:0] RESYNC_WORD    = 32'h416FDC1E,
    parameter logic [31:0] MAGIC_WORD     = 32'hD78C1B74,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    pc_rx_packet_sequencer_if.master       io_bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;

    localparam logic [15:0]     MAX_LEN = 16'(MAX_WORDS);
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      r_state;
    logic            r_pending;
    logic            r_valid;
    logic            r_last;
    logic            r_start;
    logic            r_error;
    logic [31:0]     r_word;
    logic [15:0]     r_length;
    logic [1:0]      r_code;
    logic [15:0]     r_count;
    logic [15:0]     r_remaining;
    logic [TO_W-1:0] r_timeout;

    logic        w_read;
    logic        w_xfer;
    logic        w_active;
    logic        w_tick;
    logic        w_expire;
    logic [15:0] w_len;
    logic        w_len_ok;

    // Reads are gated by reset so the request drops the moment reset is raised.
    assign w_read   = !i_reset && !io_bus.i_fifo_is_empty_sig && !r_pending && !r_valid;
    assign w_xfer   = r_valid && io_bus.i_payload_ready;
    assign w_active = (r_state == S_LEN) || (r_state == S_DATA);
    // Only starvation counts. A held output word is the consumer's stall, not the link's.
    assign w_tick   = w_active && io_bus.i_fifo_is_empty_sig && !r_pending && !r_valid;
    assign w_expire = w_tick && (r_timeout == TO_LAST);
    assign w_len    = io_bus.i_fifo_output_word[15:0];
    assign w_len_ok = (w_len != 16'd0) && (w_len <= MAX_LEN);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_start     <= 1'b0;
            r_error     <= 1'b0;
            r_word      <= 32'd0;
            r_length    <= 16'd0;
            r_code      <= 2'd0;
            r_count     <= 16'd0;
            r_remaining <= 16'd0;
            r_timeout   <= '0;
        end else begin
            r_pending <= w_read;
            r_start   <= 1'b0;
            r_error   <= 1'b0;

            if (w_xfer) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                if (r_last) begin
                    r_state <= S_IDLE;
                    r_count <= r_count + 16'd1;
                end
            end

            // The FIFO word is valid in the cycle after the read request.
            // Capture cannot coincide with expiry because expiry needs no read pending.
            if (r_pending) begin
                case (r_state)
                    S_IDLE: begin
                        if (io_bus.i_fifo_output_word == RESYNC_WORD)
                            r_state <= S_PRE;
                    end
                    S_PRE: begin
                        if (io_bus.i_fifo_output_word == MAGIC_WORD) begin
                            r_state <= S_LEN;
                        end else if (io_bus.i_fifo_output_word != RESYNC_WORD) begin
                            r_state <= S_IDLE;
                            r_error <= 1'b1;
                            r_code  <= 2'd3;
                        end
                    end
                    S_LEN: begin
                        if (io_bus.i_fifo_output_word == RESYNC_WORD) begin
                            r_state <= S_PRE;
                        end else if (w_len_ok) begin
                            r_state     <= S_DATA;
                            r_remaining <= w_len;
                            r_length    <= w_len;
                            r_start     <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_error <= 1'b1;
                            r_code  <= 2'd1;
                        end
                    end
                    S_DATA: begin
                        r_word      <= io_bus.i_fifo_output_word;
                        r_valid     <= 1'b1;
                        r_last      <= (r_remaining == 16'd1);
                        r_remaining <= r_remaining - 16'd1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_expire) begin
                r_state <= S_IDLE;
                r_error <= 1'b1;
                r_code  <= 2'd2;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end

            if (!w_active || r_pending || w_expire || (w_xfer && r_last))
                r_timeout <= '0;
            else if (w_tick)
                r_timeout <= r_timeout + 1'b1;
        end
    end

    assign io_bus.o_read_next_byte_cmd = w_read;
    assign io_bus.o_payload_word       = r_word;
    assign io_bus.o_payload_valid      = r_valid;
    assign io_bus.o_payload_last       = r_last;
    assign io_bus.o_packet_start       = r_start;
    assign io_bus.o_packet_length      = r_length;
    assign io_bus.o_error              = r_error;
    assign io_bus.o_error_code         = r_code;
    assign io_bus.o_packet_count       = r_count;
    assign io_bus.o_state              = r_state;
endmodule

// File: tb/tb_pc_rx_packet_sequencer.sv
// Directed bench for pc_rx_packet_sequencer with a queue-based model of the receive FIFO.
// It records the observed pulses and transfers, then asserts them against hand-computed values.
module tb_pc_rx_packet_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_rx_packet_sequencer_if bus_if ();

    pc_rx_packet_sequencer #(
        .TIMEOUT_CYCLES (100)
    ) u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus_if.master)
    );

    logic [31:0] fifo_q[$];
    logic [31:0] rx_word[$];
    logic        rx_last[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cnt, err_cnt, rd_cnt, err_cyc, xfer_cyc;
    logic [15:0] len_seen;
    logic [31:0] held_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rxw(input int i);
        return (i < rx_word.size()) ? rx_word[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic rxl(input int i);
        return (i < rx_last.size()) ? rx_last[i] : 1'bx;
    endfunction

    task automatic clear_rec();
        rx_word.delete();
        rx_last.delete();
        start_cnt = 0;
        err_cnt   = 0;
        rd_cnt    = 0;
        err_cyc   = -1;
        xfer_cyc  = -1;
        len_seen  = 16'd0;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        bus_if.i_fifo_is_empty_sig = 1'b0;
    endtask

    // Entered and left at a falling edge. The FIFO model pops just after the edge that saw rdreq.
    task automatic step();
        logic rd;
        #1;
        rd = bus_if.o_read_next_byte_cmd;
        if (rd) rd_cnt++;
        if (bus_if.o_payload_valid && bus_if.i_payload_ready) begin
            rx_word.push_back(bus_if.o_payload_word);
            rx_last.push_back(bus_if.o_payload_last);
            xfer_cyc = cyc;
        end
        if (bus_if.o_packet_start) begin
            start_cnt++;
            len_seen = bus_if.o_packet_length;
        end
        if (bus_if.o_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) bus_if.i_fifo_output_word = fifo_q.pop_front();
        bus_if.i_fifo_is_empty_sig = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        bus_if.i_fifo_output_word  = 32'd0;
        bus_if.i_fifo_is_empty_sig = 1'b1;
        bus_if.i_payload_ready     = 1'b0;
        clear_rec();

        #1 rst = 1'b1;
        #1;
        chk("reset_state", 32'(bus_if.o_state), 32'd0);
        chk("reset_valid", 32'(bus_if.o_payload_valid), 32'd0);
        chk("reset_count", 32'(bus_if.o_packet_count), 32'd0);
        chk("reset_rdreq", 32'(bus_if.o_read_next_byte_cmd), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Nominal three-word packet with the consumer always ready
        bus_if.i_payload_ready = 1'b1;
        push(32'h416FDC1E); push(32'hD78C1B74); push(32'h00000003);
        push(32'hAAAA0001); push(32'hAAAA0002); push(32'hAAAA0003);
        run(20);
        chk("nom_start_cnt", 32'(start_cnt), 32'd1);
        chk("nom_length", 32'(len_seen), 32'd3);
        chk("nom_rx_size", 32'(rx_word.size()), 32'd3);
        chk("nom_word0", rxw(0), 32'hAAAA0001);
        chk("nom_word1", rxw(1), 32'hAAAA0002);
        chk("nom_word2", rxw(2), 32'hAAAA0003);
        chk("nom_last0", 32'(rxl(0)), 32'd0);
        chk("nom_last1", 32'(rxl(1)), 32'd0);
        chk("nom_last2", 32'(rxl(2)), 32'd1);
        chk("nom_state", 32'(bus_if.o_state), 32'd0);
        chk("nom_count", 32'(bus_if.o_packet_count), 32'd1);
        chk("nom_errors", 32'(err_cnt), 32'd0);

        // Backpressure: first payload word held for 10 cycles
        clear_rec();
        bus_if.i_payload_ready = 1'b0;
        push(32'h416FDC1E); push(32'hD78C1B74); push(32'h00000003);
        push(32'hBBBB0001); push(32'hBBBB0002); push(32'hBBBB0003);
        run(12);
        chk("bp_valid_up", 32'(bus_if.o_payload_valid), 32'd1);
        chk("bp_word_up", bus_if.o_payload_word, 32'hBBBB0001);
        held_word = bus_if.o_payload_word;
        rd_cnt = 0;
        run(10);
        chk("bp_valid_held", 32'(bus_if.o_payload_valid), 32'd1);
        chk("bp_word_held", bus_if.o_payload_word, held_word);
        chk("bp_last_held", 32'(bus_if.o_payload_last), 32'd0);
        chk("bp_no_rdreq", 32'(rd_cnt), 32'd0);
        chk("bp_no_error", 32'(err_cnt), 32'd0);
        chk("bp_state", 32'(bus_if.o_state), 32'd3);
        bus_if.i_payload_ready = 1'b1;
        run(20);
        chk("bp_rx_size", 32'(rx_word.size()), 32'd3);
        chk("bp_word1", rxw(1), 32'hBBBB0002);
        chk("bp_word2", rxw(2), 32'hBBBB0003);
        chk("bp_last2", 32'(rxl(2)), 32'd1);
        chk("bp_count", 32'(bus_if.o_packet_count), 32'd2);

        // Garbage before the resync is dropped silently, then a zero length is rejected
        clear_rec();
        push(32'h12345678);
        run(4);
        chk("garbage_no_error", 32'(err_cnt), 32'd0);
        chk("garbage_state", 32'(bus_if.o_state), 32'd0);
        push(32'h416FDC1E); push(32'hD78C1B74); push(32'h00000000);
        run(10);
        chk("len0_err_cnt", 32'(err_cnt), 32'd1);
        chk("len0_code", 32'(bus_if.o_error_code), 32'd1);
        chk("len0_no_start", 32'(start_cnt), 32'd0);
        chk("len0_state", 32'(bus_if.o_state), 32'd0);

        // One above the maximum length is rejected
        clear_rec();
        push(32'h416FDC1E); push(32'hD78C1B74); push(32'h00000401);
        run(10);
        chk("len401_err_cnt", 32'(err_cnt), 32'd1);
        chk("len401_code", 32'(bus_if.o_error_code), 32'd1);
        chk("len401_no_payload", 32'(rx_word.size()), 32'd0);
        chk("len401_state", 32'(bus_if.o_state), 32'd0);
        chk("len401_count", 32'(bus_if.o_packet_count), 32'd2);

        // Bad magic
        clear_rec();
        push(32'h416FDC1E); push(32'hDEADBEEF);
        run(8);
        chk("magic_err_cnt", 32'(err_cnt), 32'd1);
        chk("magic_code", 32'(bus_if.o_error_code), 32'd3);
        chk("magic_state", 32'(bus_if.o_state), 32'd0);

        // A repeated resync re-arms. A payload equal to the resync word is still forwarded.
        clear_rec();
        push(32'h416FDC1E); push(32'h416FDC1E); push(32'hD78C1B74);
        run(10);
        chk("resync_state_len", 32'(bus_if.o_state), 32'd2);
        chk("resync_no_error", 32'(err_cnt), 32'd0);
        push(32'h00000001); push(32'h416FDC1E);
        run(10);
        chk("resync_len1", 32'(len_seen), 32'd1);
        chk("resync_payload", rxw(0), 32'h416FDC1E);
        chk("resync_last", 32'(rxl(0)), 32'd1);
        chk("resync_count", 32'(bus_if.o_packet_count), 32'd3);

        // Timeout. The first word transfers in cycle c+2. Starvation runs from c+3 to c+102,
        // so the error pulse is sampled in cycle c+103, 101 samples after the transfer.
        clear_rec();
        push(32'h416FDC1E); push(32'hD78C1B74); push(32'h00000003); push(32'hCCCC0001);
        run(150);
        chk("to_rx_size", 32'(rx_word.size()), 32'd1);
        chk("to_err_cnt", 32'(err_cnt), 32'd1);
        chk("to_code", 32'(bus_if.o_error_code), 32'd2);
        chk("to_latency", 32'(err_cyc - xfer_cyc), 32'd101);
        chk("to_state", 32'(bus_if.o_state), 32'd0);
        chk("to_count", 32'(bus_if.o_packet_count), 32'd3);
        clear_rec();
        push(32'h416FDC1E); push(32'hD78C1B74); push(32'h00000001); push(32'hDDDD0001);
        run(15);
        chk("after_to_word", rxw(0), 32'hDDDD0001);
        chk("after_to_count", 32'(bus_if.o_packet_count), 32'd4);
        chk("after_to_no_err", 32'(err_cnt), 32'd0);

        // Asynchronous reset in the middle of a held payload word
        clear_rec();
        bus_if.i_payload_ready = 1'b0;
        push(32'h416FDC1E); push(32'hD78C1B74); push(32'h00000004);
        push(32'hEEEE0001); push(32'hEEEE0002);
        run(12);
        chk("pre_rst_state", 32'(bus_if.o_state), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(bus_if.o_state), 32'd0);
        chk("arst_valid", 32'(bus_if.o_payload_valid), 32'd0);
        chk("arst_word", bus_if.o_payload_word, 32'd0);
        chk("arst_count", 32'(bus_if.o_packet_count), 32'd0);
        chk("arst_length", 32'(bus_if.o_packet_length), 32'd0);
        chk("arst_code", 32'(bus_if.o_error_code), 32'd0);
        chk("arst_rdreq", 32'(bus_if.o_read_next_byte_cmd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_rec();
        bus_if.i_payload_ready = 1'b1;
        push(32'h12345678); push(32'h416FDC1E); push(32'hD78C1B74);
        push(32'h12340002); push(32'hFFFF0001); push(32'hFFFF0002);
        run(30);
        chk("post_rst_rx_size", 32'(rx_word.size()), 32'd2);
        chk("post_rst_word0", rxw(0), 32'hFFFF0001);
        chk("post_rst_word1", rxw(1), 32'hFFFF0002);
        chk("post_rst_last0", 32'(rxl(0)), 32'd0);
        chk("post_rst_last1", 32'(rxl(1)), 32'd1);
        chk("post_rst_length", 32'(len_seen), 32'd2);
        chk("post_rst_count", 32'(bus_if.o_packet_count), 32'd1);
        chk("post_rst_no_err", 32'(err_cnt), 32'd0);
        chk("post_rst_state", 32'(bus_if.o_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
